datapath_ctrl: RTL and testbench

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/datapath_ctrl_pkg.sv | 30 +++
 rtl/datapath_ctrl_mul.sv | 57 +++++
 rtl/datapath_ctrl.sv | 141 ++++++++++++++
 tb/tb_datapath_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath controller: op encodings, FSM states,
// default data width.
package datapath_ctrl_pkg;

    localparam int unsigned DEF_W = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MUL  = 3'b100,
        OP_LDI  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    // Reserved encodings retire without touching the register file.
    function automatic logic op_writes(input op_t op);
        return (op != OP_RSV6) && (op != OP_RSV7);
    endfunction

endpackage

// File: rtl/datapath_ctrl_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first,
// low W bits of the product available after W cycles.
module seq_multiplier
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_product,
    output logic         o_valid,
    output logic         o_last
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_mcand;
    logic [W-1:0]  r_mplier;
    logic [CW-1:0] r_count;
    logic          r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_count  <= CW'(W);
            r_valid  <= 1'b0;
        end else if (r_count != '0) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_product = r_acc;
    assign o_valid   = r_valid;
    // High during the cycle whose closing edge performs the final step.
    assign o_last    = (r_count == CW'(1));

endmodule

// File: rtl/datapath_ctrl.sv
// Single-issue controller: accepts one instruction, reads two registers,
// executes (ALU or iterative MUL) and writes the result back.
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   op,
    input  logic [1:0]   rd,
    input  logic [1:0]   rs1,
    input  logic [1:0]   rs2,
    input  logic [W-1:0] imm,
    input  logic [W-1:0] rf_out1,
    input  logic [W-1:0] rf_out2,
    output logic [1:0]   rf_addr_out1,
    output logic [1:0]   rf_addr_out2,
    output logic         rf_we,
    output logic [1:0]   rf_addr_input,
    output logic [W-1:0] rf_data,
    output logic         busy,
    output logic         done
);

    state_t       r_state;
    state_t       w_next;
    op_t          r_op;
    logic [1:0]   r_rd;
    logic [1:0]   r_rs1;
    logic [1:0]   r_rs2;
    logic [W-1:0] r_imm;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_result;
    logic [W-1:0] w_alu;
    logic         w_accept;
    logic         w_mul_start;
    logic [W-1:0] w_mul_product;
    logic         w_mul_valid;
    logic         w_mul_last;

    assign w_accept    = instr_valid && (r_state == ST_IDLE);
    // Multiplier loads straight from the read ports at the same edge as A/B.
    assign w_mul_start = (r_state == ST_READ) && (r_op == OP_MUL);

    seq_multiplier #(.W(W)) u_mul (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_start   (w_mul_start),
        .i_a       (rf_out1),
        .i_b       (rf_out2),
        .o_product (w_mul_product),
        .o_valid   (w_mul_valid),
        .o_last    (w_mul_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        done        = 1'b0;
        rf_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (w_accept) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: w_next = ST_EXEC;
            ST_EXEC: begin
                if ((r_op != OP_MUL) || w_mul_last) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                done   = 1'b1;
                rf_we  = op_writes(r_op);
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (r_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            OP_LDI:  w_alu = r_imm;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= OP_ADD;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op_t'(op);
                r_rd  <= rd;
                r_rs1 <= rs1;
                r_rs2 <= rs2;
                r_imm <= imm;
            end
            if (r_state == ST_READ) begin
                r_a <= rf_out1;
                r_b <= rf_out2;
            end
            if ((r_state == ST_EXEC) && (r_op != OP_MUL)) begin
                r_result <= w_alu;
            end
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign rf_addr_out1  = r_rs1;
    assign rf_addr_out2  = r_rs2;
    assign rf_addr_input = r_rd;
    assign rf_data       = ((r_op == OP_MUL) && w_mul_valid) ? w_mul_product : r_result;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl with a 4-entry register file and an
// instruction-level reference model checked every cycle.
module tb_datapath_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [31:0] imm;
    logic [31:0] rf_out1;
    logic [31:0] rf_out2;
    logic [1:0]  rf_addr_out1;
    logic [1:0]  rf_addr_out2;
    logic        rf_we;
    logic [1:0]  rf_addr_input;
    logic [31:0] rf_data;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    datapath_ctrl #(.W(32)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .op            (op),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .imm           (imm),
        .rf_out1       (rf_out1),
        .rf_out2       (rf_out2),
        .rf_addr_out1  (rf_addr_out1),
        .rf_addr_out2  (rf_addr_out2),
        .rf_we         (rf_we),
        .rf_addr_input (rf_addr_input),
        .rf_data       (rf_data),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf [4];
    initial for (int i = 0; i < 4; i++) rf[i] = '0;
    always @(posedge clk) if (rf_we) rf[rf_addr_input] <= rf_data;
    assign rf_out1 = rf[rf_addr_out1];
    assign rf_out2 = rf[rf_addr_out2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    // Reference model: one instruction at a time, result computed at accept
    // from the architectural register values, retired after a fixed latency.
    int          cyc = 0;
    logic        m_busy = 1'b0;
    int          m_acc = 0;
    int          m_lat = 0;
    logic        m_we = 1'b0;
    logic [1:0]  m_rd = '0;
    logic [31:0] m_res = '0;
    logic [31:0] mregs [4];
    logic        exp_wr;
    initial for (int i = 0; i < 4; i++) mregs[i] = '0;

    function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] im);
        case (o)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a * b;
            3'd5:    return im;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_busy) begin
                if (cyc + 1 == m_acc + m_lat) begin
                    m_busy <= 1'b0;
                    if (m_we) mregs[m_rd] <= m_res;
                end
            end else if (instr_valid) begin
                m_busy <= 1'b1;
                m_acc  <= cyc + 1;
                m_rd   <= rd;
                m_we   <= (op < 3'd6);
                m_lat  <= (op == 3'd4) ? 34 : 3;
                m_res  <= model_result(op, mregs[rs1], mregs[rs2], imm);
            end
        end
    end

    assign exp_wr = m_busy && (cyc == m_acc + m_lat - 1);

    always @(negedge clk) begin
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, !m_busy});
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, exp_wr});
        chk("rf_we", {31'd0, rf_we}, {31'd0, exp_wr && m_we});
        if (exp_wr && m_we) begin
            chk("rf_addr_input", {30'd0, rf_addr_input}, {30'd0, m_rd});
            chk("rf_data", rf_data, m_res);
        end
    end

    // All tasks start and end at posedge+2.
    task automatic send(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [31:0] im, input bit hold,
                        output int acc);
        int g;
        g = 0;
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        instr_valid = 1'b1;
        while (!instr_ready && g < 100) begin
            @(posedge clk); #2;
            g++;
        end
        chk("accept_wait", {31'd0, instr_ready}, 32'd1);
        @(posedge clk); #2;
        acc = cyc;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int wedge);
        int  g;
        bit  seen;
        g = 0;
        seen = 0;
        wedge = 0;
        while (!seen && g < 100) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                wedge = cyc + 1;
            end else begin
                g++;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #2;
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [1:0] d,
                       input logic [1:0] s1, input logic [1:0] s2, input logic [31:0] im,
                       input int lat);
        int acc;
        int wedge;
        send(o, d, s1, s2, im, 1'b0, acc);
        wait_done(wedge);
        chk(name, wedge - acc, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int d1;
        int d2;
        int g;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_waddr", {30'd0, rf_addr_input}, 32'd0);
        chk("rst_wdata", rf_data, 32'd0);
        chk("rst_raddr", {28'd0, rf_addr_out1, rf_addr_out2}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        run("lat_ldi1", 3'd5, 2'd1, 2'd0, 2'd0, 32'h0000_0005, 3);
        run("lat_ldi2", 3'd5, 2'd2, 2'd0, 2'd0, 32'hFFFF_FFFF, 3);
        chk("R1_ldi", rf[1], 32'h0000_0005);
        chk("R2_ldi", rf[2], 32'hFFFF_FFFF);

        run("lat_add", 3'd0, 2'd3, 2'd1, 2'd2, 32'h1234_5678, 3);
        chk("R3_add_wrap", rf[3], 32'h0000_0004);
        run("lat_sub", 3'd1, 2'd0, 2'd1, 2'd1, 32'd0, 3);
        chk("R0_sub_zero", rf[0], 32'h0000_0000);
        run("lat_sub2", 3'd1, 2'd0, 2'd0, 2'd1, 32'd0, 3);
        chk("R0_sub_neg", rf[0], 32'hFFFF_FFFB);

        run("lat_ldi3", 3'd5, 2'd1, 2'd0, 2'd0, 32'h0000_FFFF, 3);
        run("lat_ldi4", 3'd5, 2'd2, 2'd0, 2'd0, 32'h0001_0001, 3);
        run("lat_mul", 3'd4, 2'd3, 2'd1, 2'd2, 32'd0, 34);
        chk("R3_mul", rf[3], 32'hFFFF_FFFF);

        // instr_valid held across two completions: one accept per IDLE visit
        send(3'd2, 2'd1, 2'd1, 2'd1, 32'd0, 1'b1, acc);
        d1 = 0;
        d2 = 0;
        g = 0;
        while (d2 == 0 && g < 100) begin
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = cyc;
                else d2 = cyc;
            end
            g++;
        end
        @(posedge clk); #2;
        instr_valid = 1'b0;
        chk("hold_first_done", d1 - acc, 2);
        chk("hold_done_gap", d2 - d1, 4);
        repeat (6) @(posedge clk);
        #2;
        chk("R1_and", rf[1], 32'h0000_FFFF);

        // reset during the 10th EXEC cycle of a MUL into R0
        send(3'd4, 2'd0, 2'd1, 2'd2, 32'd0, 1'b0, acc);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ready", {31'd0, instr_ready}, 32'd1);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_we", {31'd0, rf_we}, 32'd0);
        chk("async_done", {31'd0, done}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        chk("R0_after_reset", rf[0], 32'hFFFF_FFFB);
        run("lat_add2", 3'd0, 2'd3, 2'd1, 2'd2, 32'd0, 3);
        chk("R3_add2", rf[3], 32'h0002_0000);

        run("lat_rsv", 3'd6, 2'd2, 2'd1, 2'd1, 32'hDEAD_BEEF, 3);
        chk("R0_rsv", rf[0], 32'hFFFF_FFFB);
        chk("R1_rsv", rf[1], 32'h0000_FFFF);
        chk("R2_rsv", rf[2], 32'h0001_0001);
        chk("R3_rsv", rf[3], 32'h0002_0000);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
